// File: rtl/spm_seq.sv
// Serial-parallel multiplier: x is held across a carry-save array while y streams in LSB first.
// It returns the full XW+YW-bit product, unsigned or two's complement, with valid/ready handshakes.
module spm_seq #(
  parameter int XW = 32,
  parameter int YW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XW+YW-1:0] p
);

  localparam int N  = XW + YW;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            sm_q, sm_d;
  logic [XW-2:0]   sum_q, sum_d;
  logic [XW-1:0]   cry_q, cry_d;
  logic            sticky_q, sticky_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    psh_q, psh_d;
  logic [N-1:0]    p_q, p_d;

  logic            ybit;
  logic            msb_pp;
  logic [XW-1:0]   pp, s_in, fa_s, fa_c;
  logic [YW:0]     y_ext;

  // Each stage adds x[i]&ybit to the sum of the stage above and its own carry.
  // In signed mode the MSB stream is negated serially: bits are copied up to the first 1, then inverted.
  always_comb begin
    ybit           = y_q[0];
    msb_pp         = x_q[XW-1] & ybit;
    pp             = x_q & {XW{ybit}};
    pp[XW-1]       = msb_pp ^ (sm_q & sticky_q);
    s_in           = {1'b0, sum_q};
    fa_s           = pp ^ s_in ^ cry_q;
    fa_c           = (pp & s_in) | (pp & cry_q) | (s_in & cry_q);
    y_ext          = {sm_q & y_q[YW-1], y_q};
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    sm_d     = sm_q;
    sum_d    = sum_q;
    cry_d    = cry_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    psh_d    = psh_q;
    p_d      = p_q;
    if (clear) begin
      state_d  = IDLE;
      sum_d    = '0;
      cry_d    = '0;
      sticky_d = 1'b0;
      cnt_d    = '0;
      psh_d    = '0;
      p_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_d      = x;
            y_d      = y;
            sm_d     = signed_mode;
            sum_d    = '0;
            cry_d    = '0;
            sticky_d = 1'b0;
            cnt_d    = '0;
            psh_d    = '0;
            state_d  = BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == LAST) begin
            p_d     = psh_q;
            state_d = DONE;
          end else begin
            sum_d    = fa_s[XW-1:1];
            cry_d    = fa_c;
            sticky_d = sticky_q | (sm_q & msb_pp);
            y_d      = y_ext[YW:1];
            psh_d    = {fa_s[0], psh_q[N-1:1]};
            cnt_d    = cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      sm_q     <= 1'b0;
      sum_q    <= '0;
      cry_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      psh_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sm_q     <= sm_d;
      sum_q    <= sum_d;
      cry_q    <= cry_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      psh_q    <= psh_d;
      p_q      <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_spm_seq.sv
// Directed bench for spm_seq at XW=YW=8: product table, random sweep, back-pressure, abort and reset.
module tb_spm_seq;
  localparam int XW = 8;
  localparam int YW = 8;
  localparam int LAT = XW + YW + 1;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [7:0]  x, y;
  logic [15:0] p;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  spm_seq #(.XW(XW), .YW(YW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .p(p)
  );

  typedef struct {
    logic        sm;
    logic [7:0]  xv;
    logic [7:0]  yv;
    logic [15:0] pe;
  } vec_t;

  vec_t vt[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller guarantees the DUT is in IDLE at the next rising edge.
  task automatic start_txn(input logic [7:0] xv, input logic [7:0] yv, input logic sm);
    in_valid = 1'b1; x = xv; y = yv; signed_mode = sm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 8'($urandom); y = 8'($urandom); signed_mode = ~sm;
    check("accept_in_ready_low", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      x = 8'($urandom); y = 8'($urandom);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic full_txn(input string name, input logic [7:0] xv, input logic [7:0] yv,
                          input logic sm, input logic [15:0] pe);
    int lat;
    start_txn(xv, yv, sm);
    wait_done(lat);
    check({name, "_latency"}, lat, LAT);
    check({name, "_p"}, {16'd0, p}, {16'd0, pe});
    release_out();
  endtask

  initial begin
    int lat, seen, sx, sy;
    logic [7:0] rx, ry;
    logic rsm;
    logic [15:0] pe;

    vt[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vt[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vt[2]  = '{1'b1, 8'hFF, 8'h05, 16'hFFFB};
    vt[3]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vt[4]  = '{1'b0, 8'h03, 8'h07, 16'h0015};
    vt[5]  = '{1'b1, 8'hFE, 8'h03, 16'hFFFA};
    vt[6]  = '{1'b0, 8'h00, 8'hFF, 16'h0000};
    vt[7]  = '{1'b0, 8'h01, 8'h01, 16'h0001};
    vt[8]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vt[9]  = '{1'b0, 8'hFF, 8'h01, 16'h00FF};
    vt[10] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vt[11] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vt[12] = '{1'b1, 8'h01, 8'h80, 16'hFF80};
    vt[13] = '{1'b0, 8'h12, 8'h34, 16'h03A8};
    vt[14] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vt[15] = '{1'b0, 8'h80, 8'hFF, 16'h7F80};
    vt[16] = '{1'b1, 8'hFE, 8'hFD, 16'h0006};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_p", {16'd0, p}, 32'd0);

    for (int i = 0; i < 17; i++)
      full_txn($sformatf("vec%0d", i), vt[i].xv, vt[i].yv, vt[i].sm, vt[i].pe);

    for (int i = 0; i < 100; i++) begin
      rx = 8'($urandom); ry = 8'($urandom); rsm = i[0];
      sx = rsm ? int'($signed(rx)) : int'(rx);
      sy = rsm ? int'($signed(ry)) : int'(ry);
      pe = 16'(sx * sy);
      full_txn($sformatf("rand%0d", i), rx, ry, rsm, pe);
    end

    // Back-pressure: DONE held for 20 cycles while in_valid and x wiggle.
    start_txn(8'h5A, 8'h3C, 1'b0);
    wait_done(lat);
    check("bp_latency", lat, LAT);
    for (int k = 0; k < 20; k++) begin
      in_valid = k[0]; x = 8'($urandom);
      @(posedge clk); #1;
      check("bp_p_stable", {16'd0, p}, 32'h1518);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    release_out();
    check("bp_p_held_idle", {16'd0, p}, 32'h1518);

    // Abort with clear at bit 5 of BUSY.
    start_txn(8'hFF, 8'hFF, 1'b0);
    repeat (5) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("abort_no_out_valid", seen, 0);
    full_txn("after_abort", 8'h03, 8'h07, 1'b0, 16'd21);

    // Async reset in the middle of BUSY.
    start_txn(8'h7F, 8'h80, 1'b1);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_busy_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy_p", {16'd0, p}, 32'd0);
    #1 rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("rst_busy_no_out_valid", seen, 0);

    // clear and out_ready together in DONE.
    start_txn(8'hFF, 8'h05, 1'b1);
    wait_done(lat);
    check("clr_done_p_before", {16'd0, p}, 32'hFFFB);
    clear = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; out_ready = 1'b0;
    check("clr_done_in_ready", {31'd0, in_ready}, 32'd1);
    check("clr_done_out_valid", {31'd0, out_valid}, 32'd0);
    check("clr_done_p", {16'd0, p}, 32'd0);

    // Async reset while in DONE.
    start_txn(8'h12, 8'h34, 1'b0);
    wait_done(lat);
    check("rst_done_p_before", {16'd0, p}, 32'h03A8);
    #2 rst = 1'b1;
    #1;
    check("rst_done_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_done_p", {16'd0, p}, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    full_txn("after_reset", 8'hFE, 8'h03, 1'b1, 16'hFFFA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
